// File: rtl/ecc24_pkg.sv
// ecc24_pkg: shared constants, Hsiao column table, error-flag type and encoder for the 24-bit SEC-DED code
package ecc24_pkg;
    localparam int ECC24_DATA_W = 24;
    localparam int ECC24_PAR_W  = 6;
    // Odd-weight (Hsiao) columns: all twenty weight-3 codes then four weight-5 codes.
    // Any double error XORs two odd columns into an even, non-zero syndrome, so it can
    // never alias a data column or a single parity bit.
    localparam logic [ECC24_PAR_W-1:0] ECC24_COLS [ECC24_DATA_W] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };
    typedef struct packed {
        logic dbit;
        logic sbit;
    } ecc24_err_t;
    function automatic logic [ECC24_PAR_W-1:0] ecc24_enc(input logic [ECC24_DATA_W-1:0] d);
        logic [ECC24_PAR_W-1:0] p;
        p = '0;
        for (int i = 0; i < ECC24_DATA_W; i++)
            if (d[i]) p = p ^ ECC24_COLS[i];
        return p;
    endfunction
endpackage

// File: rtl/ecc_24_dec.sv
// ecc_24_dec: combinational SEC-DED decoder (syndrome, correction mask, flags)
//   data/parity : stored word and check bits
//   bypass      : pass data raw and suppress flags
//   corr        : corrected data
//   err         : {dbit,sbit} flags
module ecc_24_dec
    import ecc24_pkg::*;
(
    input  logic [ECC24_DATA_W-1:0] data,
    input  logic [ECC24_PAR_W-1:0]  parity,
    input  logic                    bypass,
    output logic [ECC24_DATA_W-1:0] corr,
    output ecc24_err_t              err
);
    logic [ECC24_PAR_W-1:0]  syn;
    logic [ECC24_DATA_W-1:0] mask;
    logic                    par_err;
    always_comb begin
        syn  = parity ^ ecc24_enc(data);
        mask = '0;
        for (int i = 0; i < ECC24_DATA_W; i++)
            mask[i] = (syn == ECC24_COLS[i]);
        // a lone set syndrome bit means the check bit itself flipped
        par_err  = $onehot(syn);
        err.sbit = !bypass && (|mask || par_err);
        err.dbit = !bypass && (syn != '0) && !(|mask) && !par_err;
        corr     = bypass ? data : data ^ mask;
    end
endmodule

// File: rtl/ecc_24_rd_stage.sv
// ecc_24_rd_stage: two-stage pipelined ECC read stage with valid/ready, error counters and irq
//   clk, rst                : clock, async active-high reset
//   in_valid/in_ready       : raw word handshake (in_addr, in_data, in_parity, bypass)
//   out_valid/out_ready     : corrected word handshake (out_data, out_addr, out_sbit_err, out_dbit_err)
//   sbit_cnt/dbit_cnt       : saturating error counters, cleared by cnt_clr
//   err_irq                 : one-cycle pulse per erroneous word entering S2
//   err_addr/err_type       : first-error log, present only when ECC24_ERR_LOG_EN is defined
module ecc_24_rd_stage
    import ecc24_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int PARITY_WIDTH = 6,
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [PARITY_WIDTH-1:0] in_parity,
    input  logic                    bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    out_sbit_err,
    output logic                    out_dbit_err,
    output logic [CNT_WIDTH-1:0]    sbit_cnt,
    output logic [CNT_WIDTH-1:0]    dbit_cnt,
    input  logic                    cnt_clr,
    output logic                    err_irq
`ifdef ECC24_ERR_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic [1:0]              err_type
`endif
);
    logic                    s1_valid;
    logic [ADDR_WIDTH-1:0]   s1_addr;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic [PARITY_WIDTH-1:0] s1_parity;
    logic                    s1_bypass;
    logic [DATA_WIDTH-1:0]   dec_data;
    ecc24_err_t              dec_err;
    logic                    s2_load;
    logic                    s2_take;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign s2_take  = s1_valid && s2_load;

    ecc_24_dec u_dec (
        .data   (s1_data),
        .parity (s1_parity),
        .bypass (s1_bypass),
        .corr   (dec_data),
        .err    (dec_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            s1_parity <= '0;
            s1_bypass <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_addr   <= in_addr;
                s1_data   <= in_data;
                s1_parity <= in_parity;
                s1_bypass <= bypass;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_addr     <= '0;
            out_sbit_err <= 1'b0;
            out_dbit_err <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= dec_data;
                out_addr     <= s1_addr;
                out_sbit_err <= dec_err.sbit;
                out_dbit_err <= dec_err.dbit;
            end
        end
    end

    // irq tracks the S2 load, not out_valid, so a stalled word pulses only once
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_irq <= 1'b0;
        else
            err_irq <= s2_take && (dec_err.sbit || dec_err.dbit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
        end else if (cnt_clr) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
        end else begin
            if (s2_take && dec_err.sbit && !(&sbit_cnt)) sbit_cnt <= sbit_cnt + 1'b1;
            if (s2_take && dec_err.dbit && !(&dbit_cnt)) dbit_cnt <= dbit_cnt + 1'b1;
        end
    end

`ifdef ECC24_ERR_LOG_EN
    // err_type==0 marks an empty log; a held sbit entry may be upgraded to dbit once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr <= '0;
            err_type <= 2'b00;
        end else if (cnt_clr) begin
            err_addr <= '0;
            err_type <= 2'b00;
        end else if (s2_take && (dec_err.sbit || dec_err.dbit) &&
                     (err_type == 2'b00 || (err_type == 2'b01 && dec_err.dbit))) begin
            err_addr <= s1_addr;
            err_type <= dec_err;
        end
    end
`endif
endmodule

// File: tb/tb_ecc_24_rd_stage.sv
module tb_ecc_24_rd_stage;
    logic        clk, rst, in_valid, bypass, out_ready, cnt_clr;
    logic [7:0]  in_addr;
    logic [23:0] in_data;
    logic [5:0]  in_parity;
    logic        in_ready, out_valid, out_sbit_err, out_dbit_err, err_irq;
    logic [23:0] out_data;
    logic [7:0]  out_addr;
    logic [15:0] sbit_cnt, dbit_cnt;
    logic        in_ready2, out_valid2, out_sbit_err2, out_dbit_err2, err_irq2;
    logic [23:0] out_data2;
    logic [7:0]  out_addr2;
    logic [1:0]  sbit_cnt2, dbit_cnt2;
`ifdef ECC24_ERR_LOG_EN
    logic [7:0]  err_addr, err_addr2;
    logic [1:0]  err_type, err_type2;
`endif

    ecc_24_rd_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_parity(in_parity), .bypass(bypass), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_sbit_err(out_sbit_err), .out_dbit_err(out_dbit_err), .sbit_cnt(sbit_cnt),
        .dbit_cnt(dbit_cnt), .cnt_clr(cnt_clr), .err_irq(err_irq)
`ifdef ECC24_ERR_LOG_EN
        , .err_addr(err_addr), .err_type(err_type)
`endif
    );

    ecc_24_rd_stage #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_addr(in_addr),
        .in_data(in_data), .in_parity(in_parity), .bypass(bypass), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_addr(out_addr2),
        .out_sbit_err(out_sbit_err2), .out_dbit_err(out_dbit_err2), .sbit_cnt(sbit_cnt2),
        .dbit_cnt(dbit_cnt2), .cnt_clr(cnt_clr), .err_irq(err_irq2)
`ifdef ECC24_ERR_LOG_EN
        , .err_addr(err_addr2), .err_type(err_type2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [23:0] d;
        logic        sb;
        logic        db;
    } exp_t;
    exp_t        q[$];
    logic [5:0]  cols[24];
    int          n_assert, n_fail;
    int          sb_exp, db_exp, irq_exp, irq_seen;
    logic [7:0]  la;
    logic [1:0]  lt;
    logic        prev_stall;
    logic [23:0] sv_data;
    logic [7:0]  sv_addr;
    logic [1:0]  sv_fl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Hsiao code: weight-3 columns ascending, then weight-5 columns ascending
    task automatic build_cols();
        int n;
        n = 0;
        for (int w = 3; w <= 5; w += 2)
            for (int v = 0; v < 64; v++)
                if ($countones(v) == w && n < 24) begin
                    cols[n] = 6'(v);
                    n++;
                end
    endtask

    function automatic logic [5:0] enc(input logic [23:0] d);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 24; i++) if (d[i]) p ^= cols[i];
        return p;
    endfunction

    // Nearest-codeword search: clean, one flipped data/check bit, or uncorrectable
    function automatic void ref_dec(input logic [23:0] d, input logic [5:0] p, input logic byp,
                                    output logic [23:0] c, output logic sb, output logic db);
        c = d; sb = 1'b0; db = 1'b0;
        if (byp || enc(d) == p) return;
        for (int i = 0; i < 24; i++)
            if (enc(d ^ (24'd1 << i)) == p) begin c = d ^ (24'd1 << i); sb = 1'b1; return; end
        for (int j = 0; j < 6; j++)
            if (enc(d) == (p ^ (6'd1 << j))) begin sb = 1'b1; return; end
        db = 1'b1;
    endfunction

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    task automatic model_push();
        exp_t e;
        ref_dec(in_data, in_parity, bypass, e.d, e.sb, e.db);
        e.a = in_addr;
        q.push_back(e);
        if (e.sb) sb_exp++;
        if (e.db) db_exp++;
        if (e.sb || e.db) begin
            irq_exp++;
            if (lt == 2'b00 || (lt == 2'b01 && e.db)) begin la = e.a; lt = {e.db, e.sb}; end
        end
    endtask

    task automatic model_clear();
        sb_exp = 0; db_exp = 0; la = '0; lt = 2'b00;
    endtask

    task automatic tick();
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, sv_data);
            chk("stall_addr", out_addr, sv_addr);
            chk("stall_flags", {out_dbit_err, out_sbit_err}, sv_fl);
        end
        if (out_valid) begin
            if (q.size() == 0) chk("dup_qsize", q.size(), 1);
            else begin
                chk("out_data", out_data, q[0].d);
                chk("out_addr", out_addr, q[0].a);
                chk("out_sbit", out_sbit_err, q[0].sb);
                chk("out_dbit", out_dbit_err, q[0].db);
                if (out_ready) void'(q.pop_front());
            end
        end
        if (in_valid && in_ready) model_push();
        if (cnt_clr) model_clear();
        prev_stall = out_valid && !out_ready;
        sv_data = out_data; sv_addr = out_addr; sv_fl = {out_dbit_err, out_sbit_err};
        irq_seen += int'(err_irq);
        @(posedge clk); #1;
    endtask

    task automatic set_word(input logic [7:0] a, input logic [23:0] d, input logic [5:0] p, input logic b);
        in_addr = a; in_data = d; in_parity = p; bypass = b;
    endtask

    task automatic send(input logic [7:0] a, input logic [23:0] d, input logic [5:0] p, input logic b);
        logic acc;
        int n;
        set_word(a, d, p, b);
        in_valid = 1'b1;
        n = 0;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) tick();
        chk("drain_qsize", q.size(), 0);
        chk("drain_valid", out_valid, 1'b0);
    endtask

    task automatic stats();
        chk("sbit_cnt", sbit_cnt, sat(sb_exp, 65535));
        chk("dbit_cnt", dbit_cnt, sat(db_exp, 65535));
        chk("sbit_cnt2", sbit_cnt2, sat(sb_exp, 3));
        chk("dbit_cnt2", dbit_cnt2, sat(db_exp, 3));
        chk("irq_count", irq_seen, irq_exp);
`ifdef ECC24_ERR_LOG_EN
        chk("err_type", err_type, lt);
        if (lt != 2'b00) chk("err_addr", err_addr, la);
`endif
    endtask

    task automatic rand_word(input logic [7:0] a, input int nflip);
        logic [29:0] cw;
        int b0, b1;
        cw[23:0] = 24'($urandom);
        cw[29:24] = enc(cw[23:0]);
        b0 = $urandom_range(29);
        b1 = (b0 + 1 + $urandom_range(28)) % 30;
        if (nflip > 0) cw[b0] = ~cw[b0];
        if (nflip > 1) cw[b1] = ~cw[b1];
        set_word(a, cw[23:0], cw[29:24], ($urandom % 8) == 0);
    endtask

    initial begin
        logic acc;
        int k;
        n_assert = 0; n_fail = 0; irq_exp = 0; irq_seen = 0; prev_stall = 1'b0;
        model_clear();
        build_cols();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        set_word(8'h00, 24'h0, 6'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 24'h0);
        chk("rst_irq", err_irq, 1'b0);
        chk("rst_sbit_cnt", sbit_cnt, 16'h0);
        chk("rst_dbit_cnt", dbit_cnt, 16'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // case 1: clean zero word, two-cycle latency
        send(8'h01, 24'h000000, 6'h00, 1'b0);
        chk("lat_cycle1", out_valid, 1'b0);
        tick();
        chk("lat_cycle2", out_valid, 1'b1);
        drain();
        stats();
        // case 2: data bit 5 flipped, single irq pulse
        send(8'h02, 24'h000020, 6'h00, 1'b0);
        tick();
        chk("c2_irq_pulse", err_irq, 1'b1);
        chk("c2_data", out_data, 24'h000000);
        tick();
        chk("c2_irq_low", err_irq, 1'b0);
        drain();
        chk("c2_sbit_cnt", sbit_cnt, 16'd1);
        stats();
        // case 3: check-bit error
        send(8'h03, 24'h000000, 6'h01, 1'b0);
        drain();
        stats();
        // case 4: double data error
        send(8'h04, 24'h000003, 6'h00, 1'b0);
        drain();
        chk("c4_dbit_cnt", dbit_cnt, 16'd1);
        stats();

        // case 5: 8-word stream with out_ready toggling; word 3 is bypassed bit-5 error
        k = 0;
        for (int c = 0; c < 80 && k < 8; c++) begin
            out_ready = (c % 2) == 0;
            if (k == 3) set_word(8'h13, 24'h000020, 6'h00, 1'b1);
            else rand_word(8'(8'h10 + k), k % 3);
            in_valid = 1'b1;
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        chk("c5_sent", k, 8);
        drain();
        stats();

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            rand_word(8'($urandom), $urandom_range(2));
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            tick();
        end
        drain();
        stats();

        // case 6: saturation on the 2-bit instance
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        stats();
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 24'h1 << $urandom_range(23), 6'h00, 1'b0);
        drain();
        chk("sat_cnt2", sbit_cnt2, 2'd3);
        chk("sat_cnt16", sbit_cnt, 16'd5);
        stats();
        // clear in the same cycle the erroneous word loads S2
        send(8'h50, 24'h000800, 6'h00, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        drain();
        chk("clr_wins", sbit_cnt, 16'd0);
        stats();

        // reset with S1 and S2 both occupied
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_word(8'(8'h60 + i), 24'(24'h111111 * (i + 1)), enc(24'(24'h111111 * (i + 1))), 1'b0);
            in_valid = 1'b1;
            tick();
        end
        chk("pre_rst_valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        chk("post_edge_valid", out_valid, 1'b0);
        rst = 1'b0;
        q.delete();
        prev_stall = 1'b0;
        model_clear();
        stats();
        send(8'h70, 24'hABCDEF, enc(24'hABCDEF), 1'b0);
        drain();
        stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
